// File: rtl/spi_frame_controller.sv
// rtl/spi_frame_controller.sv - SPI frame decoder driving memory bursts, read-back and config writes
module spi_frame_controller #(
   parameter int         ADDR_BYTES = 2,
   parameter int         RD_LATENCY = 1,
   parameter int         BURST_EN   = 1,
   parameter int         CFG_IDX_W  = 4,
   parameter logic [7:0] OP_WR      = 8'h01,
   parameter logic [7:0] OP_RD      = 8'h03,
   parameter logic [7:0] OP_CLKDIV  = 8'h05,
   parameter logic [7:0] OP_SPIKE   = 8'h07,
   parameter logic [7:0] OP_DEBUG   = 8'h09
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cs,
   input  logic                      data_valid,
   input  logic [7:0]                rx_byte,
   output logic                      mem_wr_en,
   output logic                      mem_rd_en,
   output logic [8*ADDR_BYTES-1:0]   mem_addr,
   output logic [7:0]                mem_wdata,
   input  logic [7:0]                mem_rdata,
   output logic [7:0]                tx_byte,
   output logic                      tx_load,
   output logic                      cfg_wr_en,
   output logic [2:0]                cfg_sel,
   output logic [CFG_IDX_W-1:0]      cfg_idx,
   output logic [7:0]                cfg_wdata,
   output logic [2:0]                cfg_ready,
   output logic                      frame_error
);

   localparam int ADDR_W = 8 * ADDR_BYTES;
   localparam int CNT_W  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
   localparam logic [CNT_W-1:0]     ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
   localparam logic [ADDR_W-1:0]    ADDR_STEP = (BURST_EN != 0) ? ADDR_W'(1) : '0;
   localparam logic [CFG_IDX_W-1:0] CFG_MAX   = {CFG_IDX_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      OPCODE,
      ADDR,
      WDATA,
      RDATA,
      CFG,
      IGNORE
   } state_t;

   state_t                 state;
   logic [ADDR_W-1:0]      addr_q;
   logic [CNT_W-1:0]       addr_cnt;
   logic                   is_rd;
   logic [CFG_IDX_W-1:0]   cfg_cnt;
   logic                   cfg_any;
   logic [RD_LATENCY-1:0]  rd_pipe;
   logic [ADDR_W-1:0]      addr_shift;
   logic [ADDR_W-1:0]      addr_inc;

   assign addr_shift = ADDR_W'({addr_q, rx_byte});
   assign addr_inc   = addr_q + ADDR_STEP;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         addr_q      <= '0;
         addr_cnt    <= '0;
         is_rd       <= 1'b0;
         cfg_cnt     <= '0;
         cfg_any     <= 1'b0;
         rd_pipe     <= '0;
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         tx_byte     <= '0;
         tx_load     <= 1'b0;
         cfg_wr_en   <= 1'b0;
         cfg_sel     <= '0;
         cfg_idx     <= '0;
         cfg_wdata   <= '0;
         cfg_ready   <= '0;
         frame_error <= 1'b0;
      end else begin
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         tx_load     <= 1'b0;
         cfg_wr_en   <= 1'b0;
         cfg_ready   <= '0;
         frame_error <= 1'b0;

         // Read return path runs independently of the FSM so reads in flight survive frame end.
         rd_pipe[0] <= mem_rd_en;
         for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
         end
         if (rd_pipe[RD_LATENCY-1]) begin
            tx_byte <= mem_rdata;
            tx_load <= 1'b1;
         end

         if (state != IDLE && cs) begin
            state <= IDLE;
            if (state == ADDR) begin
               frame_error <= 1'b1;
            end
            if (state == CFG && cfg_any) begin
               cfg_ready <= cfg_sel;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (!cs) begin
                     state <= OPCODE;
                  end
               end
               OPCODE: begin
                  if (data_valid) begin
                     addr_cnt <= '0;
                     cfg_cnt  <= '0;
                     cfg_any  <= 1'b0;
                     if (rx_byte == OP_WR || rx_byte == OP_RD) begin
                        is_rd <= (rx_byte == OP_RD);
                        state <= ADDR;
                     end else if (rx_byte == OP_CLKDIV) begin
                        cfg_sel <= 3'b001;
                        cfg_idx <= '0;
                        state   <= CFG;
                     end else if (rx_byte == OP_SPIKE) begin
                        cfg_sel <= 3'b010;
                        cfg_idx <= '0;
                        state   <= CFG;
                     end else if (rx_byte == OP_DEBUG) begin
                        cfg_sel <= 3'b100;
                        cfg_idx <= '0;
                        state   <= CFG;
                     end else begin
                        frame_error <= 1'b1;
                        state       <= IGNORE;
                     end
                  end
               end
               ADDR: begin
                  if (data_valid) begin
                     addr_q   <= addr_shift;
                     addr_cnt <= addr_cnt + 1'b1;
                     if (addr_cnt == ADDR_LAST) begin
                        if (is_rd) begin
                           state     <= RDATA;
                           mem_rd_en <= 1'b1;
                           mem_addr  <= addr_shift;
                        end else begin
                           state <= WDATA;
                        end
                     end
                  end
               end
               WDATA: begin
                  if (data_valid) begin
                     mem_wr_en <= 1'b1;
                     mem_addr  <= addr_q;
                     mem_wdata <= rx_byte;
                     addr_q    <= addr_inc;
                  end
               end
               RDATA: begin
                  // Each dummy byte fetches the next location for the following transmit slot.
                  if (data_valid) begin
                     addr_q    <= addr_inc;
                     mem_addr  <= addr_inc;
                     mem_rd_en <= 1'b1;
                  end
               end
               CFG: begin
                  if (data_valid) begin
                     cfg_wr_en <= 1'b1;
                     cfg_wdata <= rx_byte;
                     cfg_idx   <= cfg_cnt;
                     cfg_any   <= 1'b1;
                     if (cfg_cnt != CFG_MAX) begin
                        cfg_cnt <= cfg_cnt + 1'b1;
                     end
                  end
               end
               IGNORE: begin
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/spi_frame_controller.md
Name: spi_frame_controller

Overview:
Parametrised successor of the SPI control unit. Decodes SPI frames into memory write/read bursts and configuration-register writes. Frame format: one opcode byte, then ADDR_BYTES address bytes (MSB first, memory opcodes only), then data bytes. Sits between the SPI byte deserialiser/serialiser and the weight/state memory and config registers, and adds burst auto-increment, memory read-back and indexed config writes.

Parameters:
ADDR_BYTES, 2, number of address bytes per memory frame; ADDR_W = 8*ADDR_BYTES (localparam).
RD_LATENCY, 1, memory read latency in cycles (1..4).
BURST_EN, 1, 1 = address auto-increments per data byte; 0 = address held.
CFG_IDX_W, 4, width of config byte index.
OP_WR, 8'h01 / OP_RD, 8'h03 / OP_CLKDIV, 8'h05 / OP_SPIKE, 8'h07 / OP_DEBUG, 8'h09, opcode values.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs  in  1  SPI chip select, active low, synchronous to clk
data_valid  in  1  one-cycle pulse: rx_byte holds a complete received byte
rx_byte  in  8  received byte
mem_wr_en  out  1  one-cycle memory write strobe
mem_rd_en  out  1  one-cycle memory read strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data, valid RD_LATENCY cycles after mem_rd_en
tx_byte  out  8  byte for the SPI serialiser
tx_load  out  1  one-cycle pulse: tx_byte updated
cfg_wr_en  out  1  one-cycle config byte write strobe
cfg_sel  out  3  one-hot config target {debug, spike, clkdiv}
cfg_idx  out  CFG_IDX_W  byte index within the config frame
cfg_wdata  out  8  config write data
cfg_ready  out  3  one-cycle end-of-frame pulse per target, same bit order as cfg_sel
frame_error  out  1  one-cycle pulse: unknown opcode, or frame aborted inside the address phase

Behaviour:
- Reset: all outputs 0, state IDLE, internal address/index 0. Reset overrides any frame in progress.
- States: IDLE, OPCODE, ADDR, WDATA, RDATA, CFG, IGNORE.
- IDLE -> OPCODE when cs=0. In any non-IDLE state, cs=1 -> IDLE in the next cycle (frame end). data_valid in a cycle with cs=1 is ignored.
- OPCODE, on data_valid: OP_WR/OP_RD -> ADDR, byte counter cleared; config opcodes -> CFG, cfg_sel latched, cfg_idx=0; any other value -> IGNORE with frame_error pulsed.
- ADDR: each data_valid shifts rx_byte into the address register MSB first. After the ADDR_BYTES-th byte: OP_WR -> WDATA; OP_RD -> RDATA, with mem_rd_en pulsed the next cycle at the full address.
- WDATA: data_valid at cycle t -> mem_wr_en=1 at t+1 with mem_addr = current address and mem_wdata = rx_byte. Address then increments if BURST_EN; the increment wraps modulo 2^ADDR_W with no error.
- RDATA: mem_rd_en at cycle t -> mem_rdata sampled at t+RD_LATENCY -> tx_byte registered and tx_load=1 at t+RD_LATENCY+1. Each subsequent data_valid (dummy byte) advances the address (BURST_EN rules) and issues mem_rd_en the next cycle. Reads in flight at frame end still complete their tx_load.
- CFG: data_valid at t -> cfg_wr_en=1 at t+1 with cfg_wdata=rx_byte and cfg_idx = count. The count then increments, saturating at 2^CFG_IDX_W-1; further bytes rewrite the last index.
- cfg_ready: pulses one cycle on frame end from CFG, only if at least one config byte was written.
- Abort: cs rises during OPCODE -> no effect. cs rises during ADDR -> frame_error pulse, no memory access. cs rises during WDATA/RDATA with zero data bytes -> no error.
- mem_addr holds its last value between frames. Strobes never assert outside the cases above.

Test Plan:
- Write burst: cs low, bytes 01,12,34,AA,BB,CC, cs high -> three mem_wr_en pulses at addresses 0x1234/0x1235/0x1236 with data AA/BB/CC, each 1 cycle after its data_valid.
- Wrap and no-burst: 01,FF,FF,11,22 -> writes at 0xFFFF then 0x0000. Repeat with BURST_EN=0 -> both writes at 0xFFFF.
- Read: RD_LATENCY=2, memory model returns low address byte; 03,00,10 then two dummy bytes -> mem_rd_en at 0x0010, 0x0011, 0x0012; tx_byte 10,11,12, each with tx_load exactly 3 cycles after its mem_rd_en.
- Config: 05,07,08 -> cfg_wr_en with cfg_sel=001, idx 0/1, data 07/08; cfg_ready=001 for one cycle after cs high. Frame of 07 alone -> no cfg_ready.
- Errors: opcode 0x42 -> frame_error pulse, no strobes until the next frame. 01,12 then cs high -> frame_error, no write. data_valid while cs=1 -> no action.
- Reset mid-frame: reset asserted after 01,12 -> all outputs 0. Next frame 01,00,05,5A -> single write at 0x0005.
